// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction-fetch stage with IF/ID pipeline register.
//
// Drives the fetch PC to an instruction memory that answers combinationally.
// On every clock edge it chooses the next PC and loads the IF/ID register that
// feeds decode.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   ROM_WORDS  instruction-memory depth in words (out-of-range detection)
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall          hold pc and IF/ID (load-use hazard)
//   flush          invalidate IF/ID on the next edge
//   branch_taken   conditional branch resolved taken in ID
//   branch_imm     signed branch offset in words
//   jump           J/JAL redirect from ID
//   jump_index     J-format 26-bit target index
//   jr             register-jump redirect from ID
//   jr_target      register-jump target address
//   imem_addr      fetch address to instruction memory (equals pc)
//   imem_data      instruction word returned for imem_addr
//   pc             current fetch PC
//   ifid_inst      registered instruction for decode
//   ifid_pc_plus4  registered PC+4 of ifid_inst
//   ifid_valid     ifid_inst holds a real fetched instruction
//   fetch_oob      sticky: a fetch was issued at pc >= ROM_WORDS*4
//
// Handshake: there is no valid/ready pair here. Decode consumes IF/ID
// whenever ifid_valid=1 and stall=0; stall=1 means decode is not ready, so
// the stage presents the same instruction again on the next cycle.
//
// IF/ID occupancy is a two-state machine (EMPTY/VALID). The state register
// is driven straight onto ifid_valid, so the machine state is directly
// observable at the port: 0 = EMPTY, 1 = VALID.
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fetch_oob
);

    typedef enum logic {
        IFID_EMPTY = 1'b0,
        IFID_VALID = 1'b1
    } ifid_state_e;

    // One bit wider than the PC so the byte limit cannot wrap for large depths.
    localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) * 33'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q,            pc_d;
    logic [31:0] ifid_inst_q,     ifid_inst_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    ifid_state_e ifid_state_q,    ifid_state_d;
    logic        fetch_oob_q,     fetch_oob_d;

    // ------------------------------------------------------------------
    // Target arithmetic
    // ------------------------------------------------------------------
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target_aligned;
    logic        redirect;
    logic        oob_now;

    assign pc_plus4      = pc_q + 32'd4;

    // Word offset -> byte offset: sign-extend then shift left by two.
    assign branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // Branch and jump targets are relative to the instruction in decode,
    // which is the one held in IF/ID, not the one currently being fetched.
    assign branch_target = ifid_pc_plus4_q + branch_offset;
    assign jump_target   = {ifid_pc_plus4_q[31:28], jump_index, 2'b00};

    // A register jump may carry a misaligned address; drop the byte bits.
    assign jr_target_aligned = jr_target & ~32'd3;

    assign redirect = jr | jump | branch_taken;
    assign oob_now  = ({1'b0, pc_q} >= ROM_LIMIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d            = pc_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_state_d    = ifid_state_q;
        fetch_oob_d     = fetch_oob_q;

        // Next PC. Redirects sit above stall: a resolved control transfer
        // must not be lost just because decode is holding for a hazard.
        if (jr) begin
            pc_d = jr_target_aligned;
        end else if (jump) begin
            pc_d = jump_target;
        end else if (branch_taken) begin
            pc_d = branch_target;
        end else if (!stall) begin
            pc_d = pc_plus4;
        end

        // IF/ID occupancy. The instruction fetched in the redirect cycle is
        // on the wrong path (there is no delay slot), so it is dropped.
        case (ifid_state_q)
            IFID_EMPTY, IFID_VALID: begin
                if (redirect || flush) begin
                    ifid_state_d    = IFID_EMPTY;
                    ifid_inst_d     = 32'd0;
                    ifid_pc_plus4_d = 32'd0;
                end else if (!stall) begin
                    ifid_state_d    = IFID_VALID;
                    ifid_inst_d     = imem_data;
                    ifid_pc_plus4_d = pc_plus4;
                end
            end
            default: begin
                ifid_state_d    = IFID_EMPTY;
                ifid_inst_d     = 32'd0;
                ifid_pc_plus4_d = 32'd0;
            end
        endcase

        // A stalled edge does not consume the fetch, so it does not count
        // as an out-of-range access. Once set the flag only clears on reset.
        if (!stall && oob_now) begin
            fetch_oob_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_PC;
            ifid_inst_q     <= 32'd0;
            ifid_pc_plus4_q <= 32'd0;
            ifid_state_q    <= IFID_EMPTY;
            fetch_oob_q     <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_state_q    <= ifid_state_d;
            fetch_oob_q     <= fetch_oob_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc            = pc_q;
    assign imem_addr     = pc_q;
    assign ifid_inst     = ifid_inst_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_valid    = (ifid_state_q == IFID_VALID);
    assign fetch_oob     = fetch_oob_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch.
//
// Directed vectors (table) plus hand-built corner sequences, then a seeded
// random phase driven from a small behavioural model. Every applied vector
// pushes its expected outputs onto exp_q; the entry is popped and compared
// one edge later, when the DUT has produced the result.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        fetch_oob;

    inst_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .fetch_oob     (fetch_oob)
    );

    // ------------------------------------------------------------------
    // Instruction memory: 32 words, 0 outside. rom[0] = 0x20040003,
    // rom[k] = 0x1000_0000 + k otherwise.
    // ------------------------------------------------------------------
    logic [31:0] rom [0:31];

    initial begin
        rom[0] = 32'h2004_0003;
        for (int k = 1; k < 32; k++) rom[k] = 32'h1000_0000 + 32'(k);
    end

    function automatic logic [31:0] rom_read(input logic [31:0] a);
        if (a < 32'd128) return rom[a[6:2]];
        return 32'd0;
    endfunction

    assign imem_data = rom_read(imem_addr);

    // ------------------------------------------------------------------
    // Vector record and scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        br;
        logic [15:0] imm;
        logic        jump;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_pp4;
        logic        e_valid;
        logic        e_oob;
    } vec_t;

    localparam int W = 98;
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(
        input logic stl, input logic fl, input logic br, input logic [15:0] imm,
        input logic jp, input logic [25:0] idx, input logic r, input logic [31:0] jt,
        input logic [31:0] e_pc, input logic [31:0] e_inst, input logic [31:0] e_pp4,
        input logic e_valid, input logic e_oob);
        vec_t v;
        v.stall = stl;   v.flush = fl;    v.br = br;     v.imm = imm;
        v.jump = jp;     v.idx = idx;     v.jr = r;      v.jt = jt;
        v.e_pc = e_pc;   v.e_inst = e_inst; v.e_pp4 = e_pp4;
        v.e_valid = e_valid; v.e_oob = e_oob;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got pc=0x%08h expected an entry", tag, pc);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " pc"},         pc,                 e[97:66]);
        check({tag, " imem_addr"},  imem_addr,          e[97:66]);
        check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e[1]});
        check({tag, " ifid_inst"},  ifid_inst,          e[65:34]);
        // PC+4 only carries meaning while the slot holds an instruction.
        if (e[1]) check({tag, " ifid_pc_plus4"}, ifid_pc_plus4, e[33:2]);
        check({tag, " fetch_oob"},  {31'd0, fetch_oob},  {31'd0, e[0]});
    endtask

    // Called at posedge+1; drives, waits one edge, compares at posedge+1.
    task automatic apply(input string tag, input vec_t v);
        stall        = v.stall;
        flush        = v.flush;
        branch_taken = v.br;
        branch_imm   = v.imm;
        jump         = v.jump;
        jump_index   = v.idx;
        jr           = v.jr;
        jr_target    = v.jt;
        exp_q.push_back({v.e_pc, v.e_inst, v.e_pp4, v.e_valid, v.e_oob});
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_imm = 16'd0;
        jump = 1'b0; jump_index = 26'd0; jr = 1'b0; jr_target = 32'd0;
    endtask

    // ------------------------------------------------------------------
    // Reference model for the random phase
    // ------------------------------------------------------------------
    logic [31:0] m_pc, m_inst, m_pp4;
    logic        m_valid, m_oob;

    task automatic model_step(inout vec_t v);
        logic [31:0] npc;
        logic        rd;
        rd = v.jr | v.jump | v.br;
        if (v.jr)         npc = {v.jt[31:2], 2'b00};
        else if (v.jump)  npc = {m_pp4[31:28], v.idx, 2'b00};
        else if (v.br)    npc = m_pp4 + 32'($signed(v.imm)) * 32'd4;
        else if (v.stall) npc = m_pc;
        else              npc = m_pc + 32'd4;
        if (!v.stall && m_pc >= 32'd128) m_oob = 1'b1;
        if (rd || v.flush) begin
            m_inst = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
        end else if (!v.stall) begin
            m_inst = rom_read(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_pc = npc;
        v.e_pc = m_pc; v.e_inst = m_inst; v.e_pp4 = m_pp4;
        v.e_valid = m_valid; v.e_oob = m_oob;
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test
    // ------------------------------------------------------------------
    vec_t vecs [21];
    vec_t v;

    initial begin
        // stl fl br imm      jp idx   jr jt        e_pc      e_inst         e_pp4     ev eo
        vecs[0]  = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h04, 32'h2004_0003, 32'h04, 1,0);
        vecs[1]  = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h08, 32'h1000_0001, 32'h08, 1,0);
        vecs[2]  = mk(0,0,0,16'h0000,1,26'd3,0,32'h00, 32'h0C, 32'h0,         32'h00, 0,0);
        vecs[3]  = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h10, 32'h1000_0003, 32'h10, 1,0);
        vecs[4]  = mk(0,0,0,16'h0000,0,26'd0,1,32'h0B, 32'h08, 32'h0,         32'h00, 0,0);
        vecs[5]  = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h0C, 32'h1000_0002, 32'h0C, 1,0);
        vecs[6]  = mk(0,0,1,16'hFFFF,0,26'd0,0,32'h00, 32'h08, 32'h0,         32'h00, 0,0);
        vecs[7]  = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h0C, 32'h1000_0002, 32'h0C, 1,0);
        vecs[8]  = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h10, 32'h1000_0003, 32'h10, 1,0);
        vecs[9]  = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h14, 32'h1000_0004, 32'h14, 1,0);
        vecs[10] = mk(1,0,0,16'h0000,0,26'd0,0,32'h00, 32'h14, 32'h1000_0004, 32'h14, 1,0);
        vecs[11] = mk(1,0,0,16'h0000,0,26'd0,0,32'h00, 32'h14, 32'h1000_0004, 32'h14, 1,0);
        vecs[12] = mk(1,0,0,16'h0000,0,26'd0,0,32'h00, 32'h14, 32'h1000_0004, 32'h14, 1,0);
        vecs[13] = mk(1,0,0,16'h0000,0,26'd0,1,32'h0B, 32'h08, 32'h0,         32'h00, 0,0);
        vecs[14] = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h0C, 32'h1000_0002, 32'h0C, 1,0);
        vecs[15] = mk(0,1,0,16'h0000,0,26'd0,0,32'h00, 32'h10, 32'h0,         32'h00, 0,0);
        vecs[16] = mk(1,1,0,16'h0000,0,26'd0,0,32'h00, 32'h10, 32'h0,         32'h00, 0,0);
        vecs[17] = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h14, 32'h1000_0004, 32'h14, 1,0);
        vecs[18] = mk(0,0,1,16'h0002,1,26'd5,0,32'h00, 32'h14, 32'h0,         32'h00, 0,0);
        vecs[19] = mk(0,0,1,16'h0001,1,26'd1,1,32'h41, 32'h40, 32'h0,         32'h00, 0,0);
        vecs[20] = mk(0,0,0,16'h0000,0,26'd0,0,32'h00, 32'h44, 32'h1000_0010, 32'h44, 1,0);

        // Reset state while rst_n is held low.
        idle_inputs();
        #12;
        check("reset pc",            pc,                  32'h0);
        check("reset ifid_inst",     ifid_inst,           32'h0);
        check("reset ifid_pc_plus4", ifid_pc_plus4,       32'h0);
        check("reset ifid_valid",    {31'd0, ifid_valid},  32'h0);
        check("reset fetch_oob",     {31'd0, fetch_oob},   32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 21; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Out-of-range fetch: sticky flag, stalled edge does not set it.
        apply("oob0", mk(0,0,0,16'h0,0,26'd0,1,32'h78, 32'h78, 32'h0,         32'h00, 0,0));
        apply("oob1", mk(0,0,0,16'h0,0,26'd0,0,32'h00, 32'h7C, 32'h1000_001E, 32'h7C, 1,0));
        apply("oob2", mk(0,0,0,16'h0,0,26'd0,0,32'h00, 32'h80, 32'h1000_001F, 32'h80, 1,0));
        apply("oob3", mk(1,0,0,16'h0,0,26'd0,0,32'h00, 32'h80, 32'h1000_001F, 32'h80, 1,0));
        apply("oob4", mk(0,0,0,16'h0,0,26'd0,0,32'h00, 32'h84, 32'h0,         32'h84, 1,1));
        apply("oob5", mk(0,0,0,16'h0,0,26'd0,1,32'h10, 32'h10, 32'h0,         32'h00, 0,1));
        apply("oob6", mk(0,0,0,16'h0,0,26'd0,0,32'h00, 32'h14, 32'h1000_0004, 32'h14, 1,1));
        apply("oob7", mk(0,0,0,16'h0,0,26'd0,0,32'h00, 32'h18, 32'h1000_0005, 32'h18, 1,1));

        // Asynchronous reset in the middle of a cycle.
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("async pc",            pc,                  32'h0);
        check("async ifid_inst",     ifid_inst,           32'h0);
        check("async ifid_pc_plus4", ifid_pc_plus4,       32'h0);
        check("async ifid_valid",    {31'd0, ifid_valid},  32'h0);
        check("async fetch_oob",     {31'd0, fetch_oob},   32'h0);

        // Redirect requested while reset is held: must be discarded.
        jump = 1'b1; jump_index = 26'd7;
        branch_taken = 1'b1; branch_imm = 16'd5;
        jr = 1'b1; jr_target = 32'h60;
        @(posedge clk);
        #1;
        check("rst_redirect pc",         pc,                 32'h0);
        check("rst_redirect ifid_valid", {31'd0, ifid_valid}, 32'h0);
        idle_inputs();
        rst_n = 1'b1;
        apply("resume", mk(0,0,0,16'h0,0,26'd0,0,32'h0, 32'h04, 32'h2004_0003, 32'h04, 1,0));

        // Random phase from the known post-resume state.
        m_pc = 32'h04; m_inst = 32'h2004_0003; m_pp4 = 32'h04; m_valid = 1'b1; m_oob = 1'b0;
        for (int n = 0; n < 300; n++) begin
            v = mk(0,0,0,16'h0,0,26'd0,0,32'h0, 32'h0,32'h0,32'h0,0,0);
            v.stall = ($urandom_range(0, 3) == 0);
            v.flush = ($urandom_range(0, 7) == 0);
            if (m_valid) begin
                v.br   = ($urandom_range(0, 7) == 0);
                v.jump = ($urandom_range(0, 7) == 0);
                v.jr   = ($urandom_range(0, 7) == 0);
            end
            v.imm = 16'($urandom_range(0, 16)) - 16'd8;
            v.idx = 26'($urandom_range(0, 40));
            v.jt  = 32'($urandom_range(0, 159));
            model_step(v);
            apply($sformatf("rand%0d", n), v);
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter ROM_WORDS, default 32, the instruction-memory depth in words, used for out-of-range detection.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold the PC and the IF/ID register (load-use hazard).
REQ-006 SHALL have port flush  input  1  invalidate the IF/ID register next edge.
REQ-007 SHALL have port branch_taken  input  1  conditional branch resolved taken in ID.
REQ-008 SHALL have port branch_imm  input  16  branch offset in words, signed.
REQ-009 SHALL have port jump  input  1  J/JAL redirect from ID.
REQ-010 SHALL have port jump_index  input  26  J-format target index.
REQ-011 SHALL have port jr  input  1  register-jump redirect from ID.
REQ-012 SHALL have port jr_target  input  32  register-jump target address.
REQ-013 SHALL have port imem_addr  output  32  fetch address to instruction memory; equals pc.
REQ-014 SHALL have port imem_data  input  32  combinational instruction word returned for imem_addr.
REQ-015 SHALL have port pc  output  32  current fetch PC register.
REQ-016 SHALL have port ifid_inst  output  32  registered instruction for decode.
REQ-017 SHALL have port ifid_pc_plus4  output  32  registered PC+4 of ifid_inst.
REQ-018 SHALL have port ifid_valid  output  1  ifid_inst holds a real fetched instruction.
REQ-019 SHALL have port fetch_oob  output  1  sticky flag: a fetch was issued at pc >= ROM_WORDS*4.

Function
REQ-020 SHALL form next-PC with priority jr > jump > branch_taken > sequential (pc+4); 32-bit wrapping add.
REQ-021 SHALL compute the branch target as ifid_pc_plus4 + (sign_extend(branch_imm) << 2).
REQ-022 SHALL compute the jump target as {ifid_pc_plus4[31:28], jump_index, 2'b00}.
REQ-023 SHALL force bits [1:0] of the jr target to 0 before loading it into pc.
REQ-024 SHALL, on a redirect (jr|jump|branch_taken), load the target into pc and clear IF/ID (ifid_inst=0, ifid_valid=0) on the same edge; no delay slot.
REQ-025 SHALL let a redirect override stall: pc loads the target and IF/ID clears even while stall=1.
REQ-026 SHALL, with stall=1 and no redirect, hold pc, ifid_inst, ifid_pc_plus4 and ifid_valid unchanged.
REQ-027 SHALL, with flush=1 and no redirect, advance pc normally (subject to stall) and clear IF/ID; flush wins over stall for IF/ID.
REQ-028 SHALL otherwise capture ifid_inst=imem_data, ifid_pc_plus4=pc+4 and ifid_valid=1 each edge; fetch-to-decode latency is 1 cycle.
REQ-029 SHALL set fetch_oob on any non-stalled edge where pc >= ROM_WORDS*4; it clears only on reset; the fetched word is captured as-is (memory returns 0).
REQ-030 SHALL treat ifid_valid as a two-state machine EMPTY/VALID: EMPTY->VALID on a normal capture, any->EMPTY on redirect/flush/reset, hold on stall.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force pc=RESET_PC, ifid_inst=0, ifid_pc_plus4=0, ifid_valid=0, fetch_oob=0.
REQ-032 SHALL resume fetch from RESET_PC on the first rising edge after rst_n deasserts; reset asserted mid-redirect SHALL discard the redirect.

Verification
REQ-033 SHALL cover: reset release, imem_data=0x20040003 -> after one edge pc=4, ifid_inst=0x20040003, ifid_pc_plus4=4, ifid_valid=1.
REQ-034 SHALL cover: jump=1, jump_index=3, ifid_pc_plus4=8 -> pc=0x0C, ifid_valid=0 next edge.
REQ-035 SHALL cover: branch_taken=1, branch_imm=16'hFFFF, ifid_pc_plus4=0x0C -> pc=0x08, IF/ID cleared.
REQ-036 SHALL cover: stall=1 for 3 cycles at pc=0x14 -> pc and IF/ID frozen; stall=1 with jr=1, jr_target=0x0B -> pc=0x08, ifid_valid=0.
REQ-037 SHALL cover: sequential run to pc=0x80 with ROM_WORDS=32 -> fetch_oob=1 and stays 1 until rst_n=0.
REQ-038 SHALL cover: jump and branch_taken asserted together -> jump target taken; rst_n pulsed low mid-cycle -> outputs reset immediately, without waiting for a clock edge.
